// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int ITER = MD_WIDTH;
  localparam int CNT_W = $clog2(MD_WIDTH + 1);
  localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_e;
endpackage

// File: rtl/multdiv_datapath.sv
// multdiv_datapath: Booth/restoring shift registers around one shared WIDTH+1-bit adder.
// Divider logic is present only when MULTDIV_DIV_EN is defined.
module multdiv_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef MULTDIV_DIV_EN
  input  op_e              op,
  input  logic             fix,
`endif
  input  logic             start,
  input  logic             step,
  input  logic             load,
  input  logic             err,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             exception
);
  localparam int W = WIDTH;
  // Multiply: {hi[W], lo[W], q-1}; divide: {rem[W+1], quotient[W]}
  logic [2*W:0] acc;
  logic [W-1:0] m;
  logic [W:0] add_a, add_b, sum;
  logic sub, mul_ovf;
`ifdef MULTDIV_DIV_EN
  op_e op_q;
  logic neg, dz, ovf;
  logic [W-1:0] mag_a, mag_b;
  assign mag_a = op_a[W-1] ? -op_a : op_a;
  assign mag_b = op_b[W-1] ? -op_b : op_b;
`endif
  assign mul_ovf = !(&acc[2*W:W] || !(|acc[2*W:W]));
  always_comb begin
    add_a = {acc[2*W], acc[2*W:W+1]};
    add_b = (acc[1] ^ acc[0]) ? {m[W-1], m} : '0;
    sub = acc[1:0] == 2'b10;
`ifdef MULTDIV_DIV_EN
    if (op_q == OP_DIV) begin
      add_a = fix ? '0 : acc[2*W-1:W-1];
      add_b = {1'b0, fix ? acc[W-1:0] : m};
      sub = 1'b1;
    end
`endif
    sum = sub ? add_a - add_b : add_a + add_b;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      m <= '0;
      result <= '0;
      exception <= 1'b0;
`ifdef MULTDIV_DIV_EN
      op_q <= OP_MUL;
      neg <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      if (start) begin
`ifdef MULTDIV_DIV_EN
        op_q <= op;
        neg <= op_a[W-1] ^ op_b[W-1];
        dz <= op_b == '0;
        ovf <= op_a == INT_MIN && op_b == '1;
        acc <= op == OP_DIV ? {{(W+1){1'b0}}, mag_a} : {{W{1'b0}}, op_b, 1'b0};
        m <= op == OP_DIV ? mag_b : op_a;
`else
        acc <= {{W{1'b0}}, op_b, 1'b0};
        m <= op_a;
`endif
      end else if (step) begin
`ifdef MULTDIV_DIV_EN
        if (op_q == OP_DIV)
          acc <= sum[W] ? {acc[2*W-1:0], 1'b0} : {sum, acc[W-2:0], 1'b1};
        else
`endif
        acc <= {sum, acc[W:1]};
      end
`ifdef MULTDIV_DIV_EN
      else if (fix && op_q == OP_DIV && neg)
        acc[W-1:0] <= sum[W-1:0];
`endif
      if (load) begin
`ifdef MULTDIV_DIV_EN
        result <= (err || (op_q == OP_DIV && dz)) ? '0 : op_q == OP_DIV ? acc[W-1:0] : acc[W:1];
        exception <= err || (op_q == OP_DIV ? (dz || ovf) : mul_ovf);
`else
        result <= err ? '0 : acc[W:1];
        exception <= err || mul_ovf;
`endif
      end
    end
  end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: 34-cycle signed multiply/divide with start/ready handshake.
// Define MULTDIV_DIV_EN to include the divider; otherwise a divide start reports an exception.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, start;
  always_comb begin
    start = (state_q == IDLE || state_q == DONE) && (ctrl_MULT || ctrl_DIV);
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (start) begin
      cnt_d = '0;
      err_d = 1'b0;
`ifdef MULTDIV_DIV_EN
      state_d = (ctrl_MULT && ctrl_DIV) ? FIX : ctrl_MULT ? MUL : DIV;
`else
      state_d = (ctrl_MULT && !ctrl_DIV) ? MUL : FIX;
`endif
      // Rejected starts skip straight to the final FIX cycle so RDY follows one edge later
      if (state_d == FIX) begin
        cnt_d = CNT_W'(ITER + 1);
        err_d = 1'b1;
      end
    end else if (state_q == MUL || state_q == DIV) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(ITER - 1) ? FIX : state_q;
    end else if (state_q == FIX) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(ITER + 1) ? DONE : FIX;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign data_resultRDY = state_q == DONE;
  assign busy = state_q == MUL || state_q == DIV || state_q == FIX;
  multdiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock,
    .reset_n,
`ifdef MULTDIV_DIV_EN
    .op       (ctrl_DIV && !ctrl_MULT ? OP_DIV : OP_MUL),
    .fix      (state_q == FIX && cnt_q == CNT_W'(ITER)),
`endif
    .start,
    .step     (state_q == MUL || state_q == DIV),
    .load     (state_q == FIX && cnt_q == CNT_W'(ITER + 1)),
    .err      (err_q),
    .op_a     (data_operandA),
    .op_b     (data_operandB),
    .result   (data_result),
    .exception(data_exception)
  );
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: table-driven and hand-sequenced checks of multdiv_unit with a result scoreboard.
module tb_multdiv_unit;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic cm = 1'b0, cd = 1'b0;
  logic [31:0] res;
  logic exc, rdy, busy;
  multdiv_unit dut (
    .clock(clock), .reset_n(reset_n), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(cm), .ctrl_DIV(cd), .data_result(res), .data_exception(exc),
    .data_resultRDY(rdy), .busy(busy)
  );
  always #5 clock = ~clock;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct {logic [31:0] res; logic exc; int lat;} exp_t;
  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; exp_t e;} vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // op: 1 = multiply, 2 = divide, 3 = both strobes (illegal)
  function automatic exp_t mk(input logic [1:0] op, input logic [31:0] r, input logic x);
    exp_t e;
    e.res = r;
    e.exc = x;
    e.lat = 34;
    if (op == 2'd3 || (op == 2'd2 && !DIV_EN)) begin
      e.res = '0;
      e.exc = 1'b1;
      e.lat = 1;
    end
    return e;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint p;
    logic [31:0] r;
    logic ex;
    if (op == 2'd1) begin
      p = longint'($signed(x)) * longint'($signed(y));
      r = p[31:0];
      ex = p != longint'($signed(r));
    end else if (y == 0) begin
      r = '0;
      ex = 1'b1;
    end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      r = x;
      ex = 1'b1;
    end else begin
      r = $signed(x) / $signed(y);
      ex = 1'b0;
    end
    return mk(op, r, ex);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb, input exp_t e);
    @(negedge clock);
    a = va;
    b = vb;
    cm = op[0];
    cd = op[1];
    @(posedge clock);
    #1;
    cm = 1'b0;
    cd = 1'b0;
    a = $urandom;
    b = $urandom;
    sb.push_back(e);
    chk("rdy_low_after_e0", {31'b0, rdy}, 32'd0);
    chk("busy_after_e0", {31'b0, busy}, 32'd1);
  endtask

  // poke > 0: pulse ctrl_DIV with fresh operands on edge E<poke> while the op is in flight
  task automatic wait_done(input int poke);
    exp_t e;
    int n = 0;
    bit busy_ok = 1'b1;
    while (!rdy && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (poke > 0 && n == poke - 1) begin
        cd = 1'b1;
        a = $urandom;
        b = $urandom;
      end
      if (n == poke) cd = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    cd = 1'b0;
    e = sb.pop_front();
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL rdy_timeout: got no RDY after %0d edges want RDY at %0d", n, e.lat);
    end else begin
      chk("latency", 32'(n), 32'(e.lat));
      chk("busy_in_flight", {31'b0, busy_ok}, 32'd1);
      chk("busy_at_rdy", {31'b0, busy}, 32'd0);
      chk("result", res, e.res);
      chk("exception", {31'b0, exc}, {31'b0, e.exc});
    end
  endtask

  initial begin
    int seen;
    logic [1:0] op;
    logic [31:0] va, vb;
    #1;
    chk("reset_result", res, 32'd0);
    chk("reset_exc", {31'b0, exc}, 32'd0);
    chk("reset_rdy", {31'b0, rdy}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tbl.push_back('{2'd1, 32'd7, 32'hFFFFFFFA, mk(2'd1, 32'hFFFFFFD6, 1'b0)});
    tbl.push_back('{2'd1, 32'h00010000, 32'h00010000, mk(2'd1, 32'h00000000, 1'b1)});
    tbl.push_back('{2'd2, 32'hFFFFFFD5, 32'd5, mk(2'd2, 32'hFFFFFFF8, 1'b0)});
    tbl.push_back('{2'd2, 32'd100, 32'd0, mk(2'd2, 32'h00000000, 1'b1)});
    tbl.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, mk(2'd2, 32'h80000000, 1'b1)});
    tbl.push_back('{2'd3, 32'd9, 32'd3, mk(2'd3, 32'h00000000, 1'b1)});
    tbl.push_back('{2'd1, 32'h80000000, 32'hFFFFFFFF, mk(2'd1, 32'h80000000, 1'b1)});
    tbl.push_back('{2'd1, 32'h80000000, 32'd1, mk(2'd1, 32'h80000000, 1'b0)});
    tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(2'd1, 32'h00000001, 1'b0)});
    tbl.push_back('{2'd2, 32'd7, 32'hFFFFFFFE, mk(2'd2, 32'hFFFFFFFD, 1'b0)});
    tbl.push_back('{2'd2, 32'h80000000, 32'd2, mk(2'd2, 32'hC0000000, 1'b0)});
    tbl.push_back('{2'd1, 32'd0, 32'h12345678, mk(2'd1, 32'h00000000, 1'b0)});
    for (int i = 0; i < 10; i++) begin
      op = i < 6 ? 2'd1 : 2'd2;
      va = $urandom;
      vb = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 40)) - 32'd20;
      tbl.push_back('{op, va, vb, model(op, va, vb)});
    end
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      wait_done(0);
    end
    issue(2'd1, 32'd3, 32'd4, mk(2'd1, 32'd12, 1'b0));
    wait_done(10);
    issue(2'd1, 32'd5, 32'd5, mk(2'd1, 32'd25, 1'b0));
    wait_done(0);
    issue(2'd1, 32'h1234, 32'h10, mk(2'd1, 32'h12340, 1'b0));
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_result", res, 32'd0);
    chk("abort_exc", {31'b0, exc}, 32'd0);
    chk("abort_rdy", {31'b0, rdy}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    void'(sb.pop_front());
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (rdy) seen++;
    end
    chk("no_rdy_after_abort", 32'(seen), 32'd0);
    issue(2'd1, 32'd2, 32'd3, mk(2'd1, 32'd6, 1'b0));
    wait_done(0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
